// File: rtl/alu_seq_ctrl.sv
// Sequencing front end for a 4-bit combinational ALU.
// Commands arrive over cmd_valid/cmd_ready. Each command drives the ALU from
// registers for one EXEC cycle. The settled result and flags then go into an
// in-order result FIFO that is drained over res_valid/res_ready. An
// accumulator keeps the last result so a command can chain it in as operand A.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready are both high. Valid does not depend on ready. While
// valid is high and ready is low, the payload and the head data stay stable.
module alu_seq_ctrl #(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic             cmd_chain,
  output logic [2:0]       alu_mod,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  input  logic [W-1:0]     alu_out,
  input  logic             alu_cout,
  input  logic             alu_cf,
  input  logic             alu_zf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic [2:0]       res_flags,
  output logic [W-1:0]     acc,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic accept;
  logic push;
  logic pop;
  logic [2:0] push_flags;

  // Each FIFO entry holds {flags, result}.
  logic [W+2:0]      mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] fifo_count;
  logic [W+2:0]      head;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: EXEC always lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: accept only in IDLE and only with FIFO space, so a push never meets a full FIFO.
  always_comb begin
    cmd_ready = (state == IDLE) && (fifo_count < FCNT_W'(DEPTH));
    accept    = cmd_valid && cmd_ready;
    push      = (state == EXEC);
    busy      = (state == EXEC);
  end

  // Only add and sub produce meaningful carry/overflow; other ops report zero only.
  always_comb begin
    if (alu_mod[2:1] == 2'b00) push_flags = {alu_cout, alu_cf, alu_zf};
    else                       push_flags = {2'b00, (alu_out == '0)};
  end

  // Operand registers, accumulator and completed-op counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_mod  <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      acc      <= '0;
      op_count <= '0;
    end else begin
      if (accept) begin
        alu_mod <= cmd_op;
        alu_a   <= cmd_chain ? acc : cmd_a;
        alu_b   <= cmd_b;
      end
      if (push) begin
        acc      <= alu_out;
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

  assign pop = res_valid && res_ready;

  // Result FIFO storage and pointers; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {push_flags, alu_out};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
        2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Head presentation; outputs read zero while the FIFO is empty.
  always_comb begin
    head      = mem[rd_ptr];
    res_valid = (fifo_count != '0);
    res_data  = res_valid ? head[W-1:0] : '0;
    res_flags = res_valid ? head[W+2:W] : 3'b000;
  end

endmodule
